// File: rtl/mef_rv32i_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Encodings match the datapath mux select and ALU mode inputs.
package mef_pkg;

  typedef enum logic [2:0] {
    CARGA      = 3'd0,
    DECODIFICA = 3'd1,
    EJECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRIBE    = 3'd4
  } estado_t;

  localparam logic [6:0] OP_LW     = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_SW     = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_FUNC = 2'd2;

  localparam logic [1:0] OP1_PC     = 2'd0;
  localparam logic [1:0] OP1_PC_ANT = 2'd1;
  localparam logic [1:0] OP1_RS1    = 2'd2;
  localparam logic [1:0] OP1_CERO   = 2'd3;

  localparam logic [1:0] OP2_RS2    = 2'd0;
  localparam logic [1:0] OP2_IMM    = 2'd1;
  localparam logic [1:0] OP2_CUATRO = 2'd2;

  localparam logic [1:0] Y_ALU_REG = 2'd0;
  localparam logic [1:0] Y_MEM     = 2'd1;
  localparam logic [1:0] Y_ALU     = 2'd2;

  typedef struct packed {
    logic       esc_pc;
    logic       branch;
    logic       sel_dir;
    logic       esc_mem;
    logic       esc_inst;
    logic       esc_reg;
    logic [2:0] sel_inmediato;
    logic [1:0] modo_alu;
    logic [1:0] sel_op1;
    logic [1:0] sel_op2;
    logic [1:0] sel_y;
  } ctrl_t;

endpackage

// File: rtl/mef_rv32i_if.sv
// Control bus between the FSM (master) and the datapath (slave).
// MEF_OP_ILEGAL_EN adds the op_ilegal flag.
interface mef_rv32i_if;
  logic [6:0] op;
  logic       esc_pc;
  logic       branch;
  logic       sel_dir;
  logic       esc_mem;
  logic       esc_inst;
  logic       esc_reg;
  logic [2:0] sel_inmediato;
  logic [1:0] modo_alu;
  logic [1:0] sel_op1;
  logic [1:0] sel_op2;
  logic [1:0] sel_y;
`ifdef MEF_OP_ILEGAL_EN
  logic       op_ilegal;
`endif

  modport master (
    input  op,
    output esc_pc, branch, sel_dir, esc_mem, esc_inst, esc_reg,
    output sel_inmediato, modo_alu, sel_op1, sel_op2, sel_y
`ifdef MEF_OP_ILEGAL_EN
    , output op_ilegal
`endif
  );

  modport slave (
    output op,
    input  esc_pc, branch, sel_dir, esc_mem, esc_inst, esc_reg,
    input  sel_inmediato, modo_alu, sel_op1, sel_op2, sel_y
`ifdef MEF_OP_ILEGAL_EN
    , input op_ilegal
`endif
  );
endinterface

// File: rtl/mef_rv32i_decodificador.sv
// Combinational decode of (state, opcode, valido) into datapath controls.
// MEF_OP_ILEGAL_EN adds the unrecognised-opcode flag.
module mef_decodificador
  import mef_pkg::*;
(
  input  estado_t    estado,
  input  logic [6:0] op,
  input  logic       valido,
  output ctrl_t      ctrl
`ifdef MEF_OP_ILEGAL_EN
  , output logic     op_ilegal
`endif
);

  always_comb begin
    ctrl = '0;
    case (estado)
      CARGA: begin
        ctrl.esc_inst = 1'b1;
        ctrl.esc_pc   = 1'b1;
        ctrl.sel_op1  = OP1_PC;
        ctrl.sel_op2  = OP2_CUATRO;
        ctrl.modo_alu = ALU_ADD;
        ctrl.sel_y    = Y_ALU;
      end
      DECODIFICA: begin
        // Branch/jal target lands in the ALU result register for later use
        ctrl.sel_op1 = OP1_PC_ANT;
        ctrl.sel_op2 = OP2_IMM;
        case (op)
          OP_JAL:  ctrl.sel_inmediato = IMM_J;
          default: ctrl.sel_inmediato = IMM_B;
        endcase
      end
      EJECUTA, MEMORIA, ESCRIBE: begin
        case (op)
          OP_LW: begin
            ctrl.sel_op1 = OP1_RS1;
            ctrl.sel_op2 = OP2_IMM;
            ctrl.sel_dir = (estado == MEMORIA);
            if (estado == ESCRIBE) begin
              ctrl.esc_reg = valido;
              ctrl.sel_y   = Y_MEM;
            end
          end
          OP_SW: begin
            ctrl.sel_op1       = OP1_RS1;
            ctrl.sel_op2       = OP2_IMM;
            ctrl.sel_inmediato = IMM_S;
            ctrl.sel_dir       = (estado == MEMORIA);
            ctrl.esc_mem       = (estado == MEMORIA);
          end
          OP_IMM: begin
            ctrl.sel_op1  = OP1_RS1;
            ctrl.sel_op2  = OP2_IMM;
            ctrl.modo_alu = ALU_FUNC;
            ctrl.esc_reg  = valido && (estado == ESCRIBE);
          end
          OP_REG: begin
            ctrl.sel_op1  = OP1_RS1;
            ctrl.sel_op2  = OP2_RS2;
            ctrl.modo_alu = ALU_FUNC;
            ctrl.esc_reg  = valido && (estado == ESCRIBE);
          end
          OP_AUIPC, OP_LUI: begin
            ctrl.sel_op1       = (op == OP_LUI) ? OP1_CERO : OP1_PC_ANT;
            ctrl.sel_op2       = OP2_IMM;
            ctrl.sel_inmediato = IMM_U;
            ctrl.esc_reg       = valido && (estado == ESCRIBE);
          end
          OP_BRANCH: begin
            ctrl.sel_op1  = OP1_RS1;
            ctrl.sel_op2  = OP2_RS2;
            ctrl.modo_alu = ALU_SUB;
            ctrl.branch   = (estado == EJECUTA);
          end
          OP_JAL: begin
            ctrl.sel_op1 = OP1_PC_ANT;
            ctrl.sel_op2 = OP2_CUATRO;
            ctrl.esc_pc  = (estado == EJECUTA);
            ctrl.esc_reg = valido && (estado == ESCRIBE);
          end
          OP_JALR: begin
            // Target computed in EJECUTA, then the link value old PC+4
            if (estado == EJECUTA) begin
              ctrl.sel_op1 = OP1_RS1;
              ctrl.sel_op2 = OP2_IMM;
            end else begin
              ctrl.sel_op1 = OP1_PC_ANT;
              ctrl.sel_op2 = OP2_CUATRO;
            end
            ctrl.esc_pc  = (estado == MEMORIA);
            ctrl.esc_reg = valido && (estado == ESCRIBE);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef MEF_OP_ILEGAL_EN
  always_comb begin
    op_ilegal = 1'b0;
    if (estado != CARGA) begin
      case (op)
        OP_LW, OP_IMM, OP_AUIPC, OP_SW, OP_REG,
        OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: op_ilegal = 1'b0;
        default: op_ilegal = 1'b1;
      endcase
    end
  end
`endif

endmodule

// File: rtl/mef_rv32i.sv
// Multicycle RV32I control FSM: fixed 5-state loop per instruction.
// MEF_OP_ILEGAL_EN exposes op_ilegal on the control bus.
module mef_rv32i
  import mef_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mef_rv32i_if.master   bus
);

  estado_t estado_q, estado_d;
  logic    valido_q, valido_d;
  ctrl_t   ctrl;

  always_comb begin
    estado_d = CARGA;
    case (estado_q)
      CARGA:      estado_d = DECODIFICA;
      DECODIFICA: estado_d = EJECUTA;
      EJECUTA:    estado_d = MEMORIA;
      MEMORIA:    estado_d = ESCRIBE;
      ESCRIBE:    estado_d = CARGA;
      default:    estado_d = CARGA;
    endcase
    // valido stays low until the first real fetch, blocking the post-reset write
    valido_d = valido_q | (estado_q == CARGA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= ESCRIBE;
      valido_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      valido_q <= valido_d;
    end
  end

`ifdef MEF_OP_ILEGAL_EN
  logic op_ilegal_dec;
`endif

  mef_decodificador u_dec (
    .estado (estado_q),
    .op     (bus.op),
    .valido (valido_q),
    .ctrl   (ctrl)
`ifdef MEF_OP_ILEGAL_EN
    , .op_ilegal (op_ilegal_dec)
`endif
  );

  assign bus.esc_pc        = ctrl.esc_pc;
  assign bus.branch        = ctrl.branch;
  assign bus.sel_dir       = ctrl.sel_dir;
  assign bus.esc_mem       = ctrl.esc_mem;
  assign bus.esc_inst      = ctrl.esc_inst;
  assign bus.esc_reg       = ctrl.esc_reg;
  assign bus.sel_inmediato = ctrl.sel_inmediato;
  assign bus.modo_alu      = ctrl.modo_alu;
  assign bus.sel_op1       = ctrl.sel_op1;
  assign bus.sel_op2       = ctrl.sel_op2;
  assign bus.sel_y         = ctrl.sel_y;
`ifdef MEF_OP_ILEGAL_EN
  assign bus.op_ilegal     = op_ilegal_dec & ~reset;
`endif

endmodule

// File: tb/tb_mef_rv32i.sv
// Directed scoreboard bench for mef_rv32i: one instruction per 5-state loop.
module tb_mef_rv32i;

  typedef struct {
    string       tag;
    int          st;
    logic [16:0] vec;
  } esp_t;

  esp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic clk = 1'b0;
  logic reset;

  mef_rv32i_if bus ();

  mef_rv32i dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {bus.esc_pc, bus.branch, bus.sel_dir, bus.esc_mem,
                     bus.esc_inst, bus.esc_reg, bus.sel_inmediato,
                     bus.modo_alu, bus.sel_op1, bus.sel_op2, bus.sel_y};

  // Field order: esc_pc branch sel_dir esc_mem esc_inst esc_reg imm modo op1 op2 y
  function automatic logic [16:0] v(input bit pc, br, dir, mem, inst, rg,
                                    input int imm, modo, o1, o2, y);
    return {pc, br, dir, mem, inst, rg, 3'(imm), 2'(modo), 2'(o1), 2'(o2), 2'(y)};
  endfunction

  function automatic bit es_legal(input logic [6:0] o);
    case (o)
      7'd3, 7'd19, 7'd23, 7'd35, 7'd51, 7'd55, 7'd99, 7'd103, 7'd111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input string tag, input int st, input logic [16:0] e);
    esp_t s;
    s.tag = tag;
    s.st  = st;
    s.vec = e;
    sb.push_back(s);
    @(posedge clk);
    #1;
    s = sb.pop_front();
    n_tests++;
    assert (obs === s.vec) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", s.tag, obs, s.vec);
    end
`ifdef MEF_OP_ILEGAL_EN
    begin
      logic il_exp;
      il_exp = (s.st != 0) && !es_legal(bus.op) && !reset;
      n_tests++;
      assert (bus.op_ilegal === il_exp) else begin
        n_fail++;
        $error("FAIL %s_ilegal observed=%b expected=%b", s.tag, bus.op_ilegal, il_exp);
      end
    end
`endif
  endtask

  task automatic run(input logic [6:0] op_in, input string tag,
                     input logic [16:0] ex, input logic [16:0] me, input logic [16:0] wb);
    bus.op = op_in;
    step({tag, "_carga"}, 0, v(1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 2));
    step({tag, "_decod"}, 1, v(0, 0, 0, 0, 0, 0, (op_in == 7'd111) ? 4 : 2, 0, 1, 1, 0));
    step({tag, "_ejecuta"}, 2, ex);
    step({tag, "_memoria"}, 3, me);
    step({tag, "_escribe"}, 4, wb);
  endtask

  initial begin
    reset  = 1'b1;
    bus.op = 'x;
    step("rst_escribe", 4, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    run(7'd3, "lw",
        v(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0),
        v(0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0),
        v(0, 0, 0, 0, 0, 1, 0, 0, 2, 1, 1));
    run(7'd35, "sw",
        v(0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0),
        v(0, 0, 1, 1, 0, 0, 1, 0, 2, 1, 0),
        v(0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0));
    run(7'd99, "beq",
        v(0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0),
        v(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0),
        v(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    run(7'd111, "jal",
        v(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0),
        v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0),
        v(0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0));
    run(7'd103, "jalr",
        v(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0),
        v(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0),
        v(0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 0));
    run(7'd19, "opimm",
        v(0, 0, 0, 0, 0, 0, 0, 2, 2, 1, 0),
        v(0, 0, 0, 0, 0, 0, 0, 2, 2, 1, 0),
        v(0, 0, 0, 0, 0, 1, 0, 2, 2, 1, 0));
    run(7'd23, "auipc",
        v(0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0),
        v(0, 0, 0, 0, 0, 0, 3, 0, 1, 1, 0),
        v(0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 0));
    run(7'd51, "opreg",
        v(0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0),
        v(0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0),
        v(0, 0, 0, 0, 0, 1, 0, 2, 2, 0, 0));
    run(7'd55, "lui",
        v(0, 0, 0, 0, 0, 0, 3, 0, 3, 1, 0),
        v(0, 0, 0, 0, 0, 0, 3, 0, 3, 1, 0),
        v(0, 0, 0, 0, 0, 1, 3, 0, 3, 1, 0));
    run(7'd127, "ilegal",
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset during EJECUTA of a load: lands in ESCRIBE with the write blocked
    bus.op = 7'd3;
    step("mid_carga", 0, v(1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 2));
    step("mid_decod", 1, v(0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0));
    step("mid_ejecuta", 2, v(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
    reset = 1'b1;
    step("mid_rst_escribe", 4, v(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1));
    reset = 1'b0;

    run(7'd19, "post_rst_opimm",
        v(0, 0, 0, 0, 0, 0, 0, 2, 2, 1, 0),
        v(0, 0, 0, 0, 0, 0, 0, 2, 2, 1, 0),
        v(0, 0, 0, 0, 0, 1, 0, 2, 2, 1, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mef_rv32i.md
Name: mef_rv32i

Overview:
- Control state machine for the multicycle RV32I core.
- Every instruction takes a fixed 5-state loop: CARGA → DECODIFICA → EJECUTA → MEMORIA → ESCRIBE → CARGA.
- Decodes the 7-bit opcode and drives the datapath write strobes and mux selects.
- Sits between the instruction register (op field) and the datapath (PC, instruction register, memory, register file, ALU).

Parameters:
- None.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
op  input  7  opcode bits [6:0] of the latched instruction
esc_pc  output  1  unconditional PC write
branch  output  1  conditional PC write; datapath gates it with the ALU condition
sel_dir  output  1  memory address select: 0=PC, 1=ALU result register
esc_mem  output  1  data memory write
esc_inst  output  1  latch instruction register and old-PC register
esc_reg  output  1  register file write
sel_inmediato  output  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J
modo_alu  output  2  0=add, 1=subtract/compare (branch), 2=decoded from funct3/funct7, 3=unused
sel_op1  output  2  ALU A: 0=PC, 1=old PC, 2=rs1, 3=zero
sel_op2  output  2  ALU B: 0=rs2, 1=immediate, 2=constant 4
sel_y  output  2  result bus: 0=ALU result register, 1=memory read data, 2=ALU direct output

Behaviour:
- State encoding: CARGA=0, DECODIFICA=1, EJECUTA=2, MEMORIA=3, ESCRIBE=4.
- Transitions advance unconditionally every clock; op does not affect sequencing.
- Outputs are Moore/Mealy combinational from (state, op). Any output not listed below is 0.
- Datapath contract: the ALU result register latches every cycle.
- Reset: synchronous; state<=ESCRIBE, valido<=0. First post-reset edge goes ESCRIBE→CARGA.
- valido: internal flag, set in CARGA. ESCRIBE asserts esc_reg only when valido=1, so the post-reset ESCRIBE never writes even with op=X.
- CARGA: sel_dir=0, esc_inst=1, sel_op1=0, sel_op2=2, modo_alu=0, sel_y=2, esc_pc=1 (PC<=PC+4).
- DECODIFICA: sel_op1=1, sel_op2=1, modo_alu=0; sel_inmediato=J if op=111, else B. Precomputes the branch/jal target into the ALU result register. No writes.
- EJECUTA, and hold the same ALU selects through MEMORIA and ESCRIBE:
  - op=3/35 (lw/sw): sel_op1=2, sel_op2=1, sel_inmediato=I/S, modo_alu=0.
  - op=19: sel_op1=2, sel_op2=1, imm I, modo_alu=2.
  - op=51: sel_op1=2, sel_op2=0, modo_alu=2.
  - op=23 (auipc): sel_op1=1, sel_op2=1, imm U, modo_alu=0.
  - op=55 (lui): sel_op1=3, sel_op2=1, imm U, modo_alu=0.
  - op=99 (branch): sel_op1=2, sel_op2=0, modo_alu=1, branch=1, sel_y=0. In MEMORIA/ESCRIBE: no strobes.
  - op=111 (jal): esc_pc=1, sel_y=0 (target from DECODIFICA); ALU computes old PC+4 (sel_op1=1, sel_op2=2) from EJECUTA through ESCRIBE.
  - op=103 (jalr): EJECUTA sel_op1=2, sel_op2=1, imm I, add. MEMORIA: esc_pc=1, sel_y=0, then ALU old PC+4 (sel_op1=1, sel_op2=2) held in ESCRIBE.
- MEMORIA: op=3 → sel_dir=1 (read). op=35 → sel_dir=1, esc_mem=1.
- ESCRIBE: esc_reg=1 for op 3 (sel_y=1) and for 19, 23, 51, 55, 103, 111 (sel_y=0). esc_reg=0 for 35, 99, unknown.
- Unknown/X opcode: treated as NOP. Only CARGA strobes fire; the loop continues.
- Reset mid-instruction: abort and return to ESCRIBE with no write.

Optional Feature:
- Macro MEF_OP_ILEGAL_EN.
- Defined: adds output op_ilegal (1 bit). It is 1 in DECODIFICA, EJECUTA, MEMORIA and ESCRIBE when op is not one of 3, 19, 23, 35, 51, 55, 99, 103, 111; 0 in CARGA and during reset.
- Undefined: port absent, behaviour otherwise identical.

Decomposition:
- Package mef_pkg: state enum, 9 opcode constants, sel_inmediato codes, modo_alu codes, sel_op1/sel_op2/sel_y codes.
- Sub-module mef_decodificador: purely combinational (state, op, valido) → outputs.
- Top holds the state and valido registers.

Test Plan:
- reset=1 for 1 cycle, op=X → next cycle in ESCRIBE with esc_reg=0; one clock later CARGA: esc_inst=1, esc_pc=1, sel_op2=2, sel_y=2.
- op=3 over 5 cycles → MEMORIA sel_dir=1, esc_mem=0; ESCRIBE esc_reg=1, sel_y=1.
- op=35 → MEMORIA esc_mem=1, sel_dir=1, sel_inmediato=1; ESCRIBE esc_reg=0.
- op=99 → EJECUTA branch=1, modo_alu=1, sel_op1=2, sel_op2=0, sel_y=0; DECODIFICA sel_inmediato=2; no esc_reg.
- op=111 and op=103 → jal: esc_pc=1 in EJECUTA; jalr: esc_pc=1 in MEMORIA; both ESCRIBE esc_reg=1, sel_op1=1, sel_op2=2.
- op=19/23/51/55 → EJECUTA modo_alu 2/0/2/0, sel_op1 2/1/2/3; ESCRIBE esc_reg=1. op=127 → no esc_reg/esc_mem (op_ilegal=1 if enabled).
